// File: rtl/seven_segment_mux_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
// Anodes are common-anode, so a digit is lit by driving its enable low.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    BLANK1 = 2'd0,
    SHOW0  = 2'd1,
    BLANK0 = 2'd2,
    SHOW1  = 2'd3
  } mux_state_t;

  localparam int DEFAULT_SHOW_CYCLES  = 24000;
  localparam int DEFAULT_BLANK_CYCLES = 480;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  function automatic logic is_show(input mux_state_t s);
    return (s == SHOW0) || (s == SHOW1);
  endfunction

endpackage

// File: rtl/seven_segment_mux_phase_timer.sv
// Phase length counter: counts 0..limit-1, where the limit is picked by
// i_sel_show, and flags the last cycle of the phase on o_done.
module phase_timer #(
  parameter int WIDTH       = 8,
  parameter int SHOW_LIMIT  = 4,
  parameter int BLANK_LIMIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_sel_show,
  output logic o_done
);

  localparam logic [WIDTH-1:0] SHOW_TC  = WIDTH'(SHOW_LIMIT - 1);
  localparam logic [WIDTH-1:0] BLANK_TC = WIDTH'(BLANK_LIMIT - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_terminal;

  assign w_terminal = i_sel_show ? SHOW_TC : BLANK_TC;
  assign o_done     = (r_count == w_terminal);

  // Holds at the terminal count rather than wrapping if nobody clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexes two hex digits onto one seven-segment decoder with blanking
// dead-time between digits; new values are committed only at the frame boundary.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int SHOW_CYCLES  = DEFAULT_SHOW_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit0_in,
  input  logic [3:0] digit1_in,
  input  logic       load,
  output logic [3:0] digit_out,
  output logic       anode0_n,
  output logic       anode1_n,
  output logic       frame_start
);

  localparam int CNT_W =
    $clog2(((SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES) + 1);

  mux_state_t r_state;
  mux_state_t w_state_next;

  logic [3:0] r_pending0;
  logic [3:0] r_pending1;
  logic [3:0] r_active0;
  logic [3:0] r_active1;
  logic [3:0] w_active0_next;
  logic [3:0] w_active1_next;

  logic [3:0] r_digit;
  logic       r_anode0_n;
  logic       r_anode1_n;
  logic       r_frame_start;

  logic w_done;
  logic w_show;
  logic w_commit;

  assign w_show   = is_show(r_state);
  assign w_commit = (r_state == SHOW1) && w_done;

  phase_timer #(
    .WIDTH       (CNT_W),
    .SHOW_LIMIT  (SHOW_CYCLES),
    .BLANK_LIMIT (BLANK_CYCLES)
  ) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_done),
    .i_sel_show (w_show),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_done) begin
      case (r_state)
        BLANK1:  w_state_next = SHOW0;
        SHOW0:   w_state_next = BLANK0;
        BLANK0:  w_state_next = SHOW1;
        default: w_state_next = BLANK1;
      endcase
    end
  end

  // A load arriving on the commit edge bypasses the pending registers.
  always_comb begin
    w_active0_next = r_active0;
    w_active1_next = r_active1;
    if (w_commit) begin
      w_active0_next = load ? digit0_in : r_pending0;
      w_active1_next = load ? digit1_in : r_pending1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BLANK1;
      r_pending0 <= 4'h0;
      r_pending1 <= 4'h0;
      r_active0  <= 4'h0;
      r_active1  <= 4'h0;
    end else begin
      r_state   <= w_state_next;
      r_active0 <= w_active0_next;
      r_active1 <= w_active1_next;
      if (load) begin
        r_pending0 <= digit0_in;
        r_pending1 <= digit1_in;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit       <= 4'h0;
      r_anode0_n    <= ANODE_OFF;
      r_anode1_n    <= ANODE_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_digit       <= ((w_state_next == BLANK1) || (w_state_next == SHOW0)) ?
                       w_active0_next : w_active1_next;
      r_anode0_n    <= (w_state_next == SHOW0) ? ANODE_ON : ANODE_OFF;
      r_anode1_n    <= (w_state_next == SHOW1) ? ANODE_ON : ANODE_OFF;
      r_frame_start <= w_commit;
    end
  end

  assign digit_out   = r_digit;
  assign anode0_n    = r_anode0_n;
  assign anode1_n    = r_anode1_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux: directed vector table, corner
// sequences for bypass and mid-frame reset, then randomized frames against a model.
module tb_seven_segment_mux;

  localparam int SHOW   = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = 2 * (SHOW + BLANK);

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       load = 1'b0;
  logic [3:0] digit0_in = 4'h0;
  logic [3:0] digit1_in = 4'h0;
  logic [3:0] digit_out;
  logic       anode0_n;
  logic       anode1_n;
  logic       frame_start;

  int assertionCount = 0;
  int failureCount = 0;

  int         edgeCount;
  logic [3:0] mPend0, mPend1, mAct0, mAct1;

  logic       propsOn = 1'b0;
  logic       prevValid = 1'b0;
  logic [3:0] prevDigit;
  logic [1:0] prevAnodes;
  int         negIdx = 0;
  int         lastFsIdx = -1;

  typedef struct packed {
    logic       ld;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] expDigit;
    logic       expAn0;
    logic       expAn1;
    logic       expFs;
  } vec_t;

  vec_t vecs[30];

  seven_segment_mux #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digit0_in   (digit0_in),
    .digit1_in   (digit1_in),
    .load        (load),
    .digit_out   (digit_out),
    .anode0_n    (anode0_n),
    .anode1_n    (anode1_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: position in the frame is just edges-since-reset mod period.
  function automatic logic [6:0] modelOutputs();
    int pos;
    logic [3:0] d;
    logic a0, a1, fs;
    pos = edgeCount % PERIOD;
    d  = (pos < BLANK + SHOW) ? mAct0 : mAct1;
    a0 = !((pos >= BLANK) && (pos < BLANK + SHOW));
    a1 = !(pos >= 2 * BLANK + SHOW);
    fs = (pos == 0) && (edgeCount > 0);
    return {d, a0, a1, fs};
  endfunction

  task automatic modelReset();
    edgeCount = 0;
    mPend0 = 4'h0; mPend1 = 4'h0;
    mAct0  = 4'h0; mAct1  = 4'h0;
  endtask

  task automatic modelEdge(input logic l, input logic [3:0] d0, input logic [3:0] d1);
    if (edgeCount % PERIOD == PERIOD - 1) begin
      mAct0 = l ? d0 : mPend0;
      mAct1 = l ? d1 : mPend1;
    end
    if (l) begin
      mPend0 = d0;
      mPend1 = d1;
    end
    edgeCount++;
  endtask

  task automatic applyStimulus(input logic l, input logic [3:0] d0, input logic [3:0] d1);
    load = l;
    digit0_in = d0;
    digit1_in = d1;
    @(posedge clk);
    modelEdge(l, d0, d1);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expected);
    logic [6:0] actual;
    actual = {digit_out, anode0_n, anode1_n, frame_start};
    assertionCount++;
    if (actual !== expected) begin
      failureCount++;
      $display("[TB] FAIL %s: got digit=%h an0=%b an1=%b fs=%b, expected digit=%h an0=%b an1=%b fs=%b",
               name, actual[6:3], actual[2], actual[1], actual[0],
               expected[6:3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic stepModel(input string name, input logic l, input logic [3:0] d0, input logic [3:0] d1);
    applyStimulus(l, d0, d1);
    checkOutput(name, modelOutputs());
  endtask

  // Free-running invariants sampled on the falling edge during the random phase.
  always @(negedge clk) begin
    if (propsOn && reset_n) begin
      negIdx++;
      assertionCount++;
      if (!anode0_n && !anode1_n) begin
        failureCount++;
        $display("[TB] FAIL anodeExclusive: an0=%b an1=%b, required not both 0", anode0_n, anode1_n);
      end
      if ((!anode0_n || !anode1_n) && prevValid && ({anode0_n, anode1_n} == prevAnodes)) begin
        assertionCount++;
        if (digit_out !== prevDigit) begin
          failureCount++;
          $display("[TB] FAIL digitStable: digit=%h changed from %h while lit", digit_out, prevDigit);
        end
      end
      if (frame_start) begin
        if (lastFsIdx >= 0) begin
          assertionCount++;
          if (negIdx - lastFsIdx != PERIOD) begin
            failureCount++;
            $display("[TB] FAIL framePeriod: got %0d cycles, required %0d", negIdx - lastFsIdx, PERIOD);
          end
        end
        lastFsIdx = negIdx;
      end
      prevDigit  = digit_out;
      prevAnodes = {anode0_n, anode1_n};
      prevValid  = 1'b1;
    end
  end

  initial begin
    // Entry i is driven before edge i+1 after reset release.
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'h3, 4'hA, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'h5, 4'h6, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'h0, 4'h0, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 4'h0, 4'h0, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 4'h7, 4'h8, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 4'h0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'h0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 4'h0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b1, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b1, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[29] = '{1'b0, 4'h0, 4'h0, 4'h8, 1'b1, 1'b1, 1'b0};

    modelReset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("resetState", {4'h0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;

    // Directed frames: first display, deferred commit, last-load-wins.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].d0, vecs[i].d1);
      checkOutput($sformatf("vec%0d", i),
                  {vecs[i].expDigit, vecs[i].expAn0, vecs[i].expAn1, vecs[i].expFs});
    end

    // Load on the commit edge goes straight to the display.
    while (edgeCount % PERIOD != PERIOD - 1) stepModel("toCommit", 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b1, 4'h9, 4'hC);
    checkOutput("bypassCommit", {4'h9, 1'b1, 1'b1, 1'b1});
    while (edgeCount % PERIOD != BLANK) stepModel("toShow0", 1'b0, 4'h0, 4'h0);
    checkOutput("bypassShow0", {4'h9, 1'b0, 1'b1, 1'b0});
    while (edgeCount % PERIOD != 2 * BLANK + SHOW) stepModel("toShow1", 1'b0, 4'h0, 4'h0);
    checkOutput("bypassShow1", {4'hC, 1'b1, 1'b0, 1'b0});

    // Asynchronous reset in the middle of SHOW1 with an uncommitted load pending.
    stepModel("midShow1", 1'b0, 4'h0, 4'h0);
    stepModel("pendingLoad", 1'b1, 4'h5, 4'h5);
    #2 reset_n = 1'b0;
    #1 checkOutput("asyncReset", {4'h0, 1'b1, 1'b1, 1'b0});
    load = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkOutput("resetHeld", {4'h0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= PERIOD; k++) begin
      stepModel("restart", 1'b0, 4'h0, 4'h0);
      if (k == BLANK) checkOutput("restartShow0", {4'h0, 1'b0, 1'b1, 1'b0});
      if (k == PERIOD) checkOutput("restartCommit", {4'h0, 1'b1, 1'b1, 1'b1});
    end

    // Randomized frames checked against the model and the invariants.
    propsOn = 1'b1;
    for (int n = 0; n < 100 * PERIOD; n++) begin
      stepModel("random", ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    propsOn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
- Time-multiplexes two hex digits onto one shared seven-segment decoder driving a dual common-anode display.
- Sits directly upstream of the 4-bit-in / 7-bit-out seven-segment decoder. It produces the nibble the decoder consumes, plus the two per-digit anode enables.
- Inserts blanking dead-time between digits to suppress ghosting.
- Commits new digit values only at frame boundaries, so a displayed pair never tears.

Parameters:
- SHOW_CYCLES, 24000, clocks each digit is lit (0.5 ms at 48 MHz); must be >= 1.
- BLANK_CYCLES, 480, clocks both anodes are off between digits; must be >= 1.
- CNT_W, $clog2(max(SHOW_CYCLES,BLANK_CYCLES)+1), phase counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit0_in  in  4  pending value for digit 0 (left).
- digit1_in  in  4  pending value for digit 1 (right).
- load  in  1  single-cycle strobe; captures digit0_in/digit1_in into pending registers.
- digit_out  out  4  nibble to seven-segment decoder input.
- anode0_n  out  1  digit 0 enable, active-low.
- anode1_n  out  1  digit 1 enable, active-low.
- frame_start  out  1  one-cycle pulse marking the frame boundary and commit point.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (reset_n). All outputs are registered.
- Reset values:
  - state = BLANK1, phase count = 0.
  - pending0, pending1, active0 and active1 = 0.
  - digit_out = 0, anode0_n = 1, anode1_n = 1, frame_start = 0.
- States and sequence: BLANK1 -> SHOW0 -> BLANK0 -> SHOW1 -> BLANK1.
  - SHOWx lasts SHOW_CYCLES clocks; BLANKx lasts BLANK_CYCLES clocks.
  - The counter runs 0..N-1 in each state, clears on every transition, and never wraps inside a state.
  - Frame period = 2*(SHOW_CYCLES+BLANK_CYCLES).
- Outputs by state:
  - anode0_n = 0 only in SHOW0; anode1_n = 0 only in SHOW1. The two anodes are never both low.
  - digit_out = active0 in BLANK1 and SHOW0; digit_out = active1 in BLANK0 and SHOW1.
  - digit_out therefore changes only during a blank phase, giving the decoder a settled input before its anode turns on.
- Load:
  - load = 1 at edge t updates pending0/pending1 at t+1.
  - Multiple loads within a frame: the last one wins.
  - load has no backpressure and is never dropped.
- Commit (SHOW1 -> BLANK1 transition):
  - active0/active1 take the pending values. If load = 1 in that same cycle, digit0_in/digit1_in are committed directly (bypass).
  - frame_start = 1 for exactly the first cycle of BLANK1.
  - Leaving reset does not assert frame_start.
- Latency:
  - A load is visible on the display no later than one frame period plus BLANK_CYCLES after its commit edge.
  - Minimum latency is 1 cycle, via the bypass case.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous), anodes go high, and a pending un-committed load is discarded.
- After reset release: BLANK1 for BLANK_CYCLES clocks, then SHOW0 showing 0. The first commit happens at the end of the first SHOW1.

Decomposition:
- Package seven_seg_pkg:
  - mux_state_t enum {BLANK1, SHOW0, BLANK0, SHOW1}.
  - Default SHOW_CYCLES/BLANK_CYCLES localparams.
  - ANODE_ON = 1'b0 / ANODE_OFF = 1'b1 constants.
- One sub-module, phase_timer: a loadable terminal-count counter with clear input and done output.
  - Parameters: width, two limits selected by a show/blank input.
  - Instantiated once; the FSM uses its done output to advance.

Test Plan (SHOW_CYCLES=4, BLANK_CYCLES=2, period 12):
1. Reset release, no load -> anodes high for 2 cycles, then anode0_n low for 4 with digit_out=0; first frame_start at cycle 12 after release.
2. load with digit0_in=3, digit1_in=A during SHOW0 -> display unchanged this frame; at the next frame_start digit_out=3, then anode0_n low; digit_out=A while anode1_n low.
3. Two loads in one frame (5/6, then 7/8) -> only 7/8 are ever displayed; 5/6 never appear.
4. load 9/C in the same cycle as the SHOW1->BLANK1 transition -> digit_out=9 in the very next BLANK1 (bypass), frame_start=1 that cycle.
5. Assert reset_n low in the middle of SHOW1 -> anode1_n=1 and digit_out=0 asynchronously, with no clock edge required; pending value discarded; restart sequence identical to scenario 1.
6. Run 100 frames with random loads -> assertions hold: anodes never both low; digit_out stable while either anode is low; frame_start period exactly 12.
